// File: rtl/regfile_writeback_if.sv
// Bundle of the writeback front end's bus-side signals: pipeline write, load issue/return,
// hazard queries and the registered regfile write port.
interface regfile_writeback_if;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_addr;
  logic        ld_issue_ready;
  logic        ld_ret_valid;
  logic [4:0]  ld_ret_addr;
  logic [31:0] ld_ret_data;
  logic        ld_ret_ready;
  logic [4:0]  rs_query_addr;
  logic [4:0]  rt_query_addr;
  logic [4:0]  rd_query_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic        rd_busy;
  logic        pipe_stall;
  logic        regfile_write_enable;
  logic [4:0]  regfile_write_addr;
  logic [31:0] regfile_write_data;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output ld_issue_valid, ld_issue_addr, ld_ret_valid, ld_ret_addr, ld_ret_data,
    output rs_query_addr, rt_query_addr, rd_query_addr,
    input  ld_issue_ready, ld_ret_ready, rs_busy, rt_busy, rd_busy, pipe_stall,
    input  regfile_write_enable, regfile_write_addr, regfile_write_data
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  ld_issue_valid, ld_issue_addr, ld_ret_valid, ld_ret_addr, ld_ret_data,
    input  rs_query_addr, rt_query_addr, rd_query_addr,
    output ld_issue_ready, ld_ret_ready, rs_busy, rt_busy, rd_busy, pipe_stall,
    output regfile_write_enable, regfile_write_addr, regfile_write_data
  );
endinterface

// File: rtl/regfile_writeback.sv
// Merges pipeline writeback and out-of-order load returns onto the single regfile write port
// and tracks registers with loads in flight. Optional starvation guard: WB_STARVE_GUARD_EN.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  regfile_writeback_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [31:0]   sb_q;
  logic [31:0]   sb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic          we_q;
  logic [4:0]    waddr_q;
  logic [31:0]   wdata_q;

  logic          fifo_empty;
  logic          fifo_full;
  logic          issue_ready;
  logic          issue_fire;
  logic          ret_push;
  logic          pop;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_addr   = addr_mem[rd_ptr_q[AW-1:0]];
  assign head_data   = data_mem[rd_ptr_q[AW-1:0]];

  assign issue_ready = (cnt_q < DEPTH_C);
  assign issue_fire  = bus.ld_issue_valid && issue_ready && (bus.ld_issue_addr != 5'd0);
  // Returns to r0 are acknowledged but never enter the FIFO.
  assign ret_push    = bus.ld_ret_valid && !fifo_full && (bus.ld_ret_addr != 5'd0);
  assign pop         = !bus.pipe_we && !fifo_empty;

  assign bus.ld_issue_ready = issue_ready;
  assign bus.ld_ret_ready   = !fifo_full;
  assign bus.rs_busy        = sb_q[bus.rs_query_addr];
  assign bus.rt_busy        = sb_q[bus.rt_query_addr];
  assign bus.rd_busy        = sb_q[bus.rd_query_addr];

  assign bus.regfile_write_enable = we_q;
  assign bus.regfile_write_addr   = waddr_q;
  assign bus.regfile_write_data   = wdata_q;

  // Set beats clear when an issue and a pop hit the same register in one cycle.
  assign sb_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_sb
      assign sb_d[gi] = (issue_fire && (bus.ld_issue_addr == 5'(gi))) ||
                        (sb_q[gi] && !(pop && (head_addr == 5'(gi))));
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (issue_fire && !pop) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!issue_fire && pop) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (ret_push) begin
      addr_mem[wr_ptr_q[AW-1:0]] <= bus.ld_ret_addr;
      data_mem[wr_ptr_q[AW-1:0]] <= bus.ld_ret_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q     <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
      if (ret_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)      rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (bus.pipe_we) begin
        we_q    <= (bus.pipe_waddr != 5'd0);
        waddr_q <= bus.pipe_waddr;
        wdata_q <= bus.pipe_wdata;
      end else if (pop) begin
        we_q    <= (head_addr != 5'd0);
        waddr_q <= head_addr;
        wdata_q <= head_data;
      end else begin
        we_q    <= 1'b0;
      end
    end
  end

`ifdef WB_STARVE_GUARD_EN
  logic [2:0] starve_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (pop) begin
      starve_q <= '0;
    end else if (bus.pipe_we && !fifo_empty && (starve_q != 3'd7)) begin
      starve_q <= starve_q + 3'd1;
    end
  end

  assign bus.pipe_stall = (starve_q == 3'd7);
`else
  assign bus.pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: vector table plus hand-written corner sequences,
// with a behavioural model feeding a queue of expected regfile writes.
module tb_regfile_writeback;
  localparam int DEPTH = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_writeback_if bus();
  regfile_writeback #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic pwe; logic [4:0] pa; logic [31:0] pd;
    logic iv;  logic [4:0] ia;
    logic rv;  logic [4:0] ra; logic [31:0] rd;
    logic [4:0] q;
    logic e_en; logic [4:0] e_a; logic [31:0] e_d; logic e_busy; logic e_irdy;
  } vec_t;

  wr_t   exp_q[$];
  wr_t   m_fifo[$];
  logic [31:0] m_sb;
  int    m_cnt;
  int    m_starve;
  vec_t  vecs[$];

  function automatic vec_t mk(logic pwe, logic [4:0] pa, logic [31:0] pd,
                              logic iv, logic [4:0] ia,
                              logic rv, logic [4:0] ra, logic [31:0] rd, logic [4:0] q,
                              logic e_en, logic [4:0] e_a, logic [31:0] e_d,
                              logic e_busy, logic e_irdy);
    vec_t v;
    v.pwe = pwe; v.pa = pa; v.pd = pd; v.iv = iv; v.ia = ia;
    v.rv = rv; v.ra = ra; v.rd = rd; v.q = q;
    v.e_en = e_en; v.e_a = e_a; v.e_d = e_d; v.e_busy = e_busy; v.e_irdy = e_irdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sb = '0;
    m_cnt = 0;
    m_starve = 0;
    m_fifo.delete();
    exp_q.delete();
  endtask

  task automatic drive_idle();
    bus.pipe_we = 1'b0; bus.pipe_waddr = '0; bus.pipe_wdata = '0;
    bus.ld_issue_valid = 1'b0; bus.ld_issue_addr = '0;
    bus.ld_ret_valid = 1'b0; bus.ld_ret_addr = '0; bus.ld_ret_data = '0;
  endtask

  // One clock cycle: drive, check ready/stall, advance model, clock, check write and busy.
  task automatic step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                      input logic iv, input logic [4:0] ia,
                      input logic rv, input logic [4:0] ra, input logic [31:0] rdat,
                      input logic [4:0] q);
    bit  irdy, rrdy;
    wr_t f;
    bus.pipe_we = pwe; bus.pipe_waddr = pa; bus.pipe_wdata = pd;
    bus.ld_issue_valid = iv; bus.ld_issue_addr = ia;
    bus.ld_ret_valid = rv; bus.ld_ret_addr = ra; bus.ld_ret_data = rdat;
    bus.rs_query_addr = q; bus.rt_query_addr = q ^ 5'd1; bus.rd_query_addr = q;
    #1;
    irdy = (m_cnt < DEPTH);
    rrdy = (m_fifo.size() < DEPTH);
    chk("issue_ready", bus.ld_issue_ready, irdy);
    chk("ret_ready", bus.ld_ret_ready, rrdy);
    chk("pipe_stall", bus.pipe_stall, GUARD && (m_starve == 7));
    if ((pwe && pa != 5'd0 && m_sb[pa]) || (iv && irdy && ia != 5'd0 && m_sb[ia])) begin
      failures++;
      $display("FAIL contract: write r%0d or issue r%0d to a busy register", pa, ia);
    end
    if (pwe) begin
      if (pa != 5'd0) begin
        f.a = pa; f.d = pd;
        exp_q.push_back(f);
      end
      if (m_fifo.size() > 0 && m_starve < 7) m_starve++;
    end else if (m_fifo.size() > 0) begin
      f = m_fifo.pop_front();
      exp_q.push_back(f);
      m_sb[f.a] = 1'b0;
      m_cnt--;
      m_starve = 0;
    end
    if (iv && irdy && ia != 5'd0) begin
      m_sb[ia] = 1'b1;
      m_cnt++;
    end
    if (rv && rrdy && ra != 5'd0) begin
      f.a = ra; f.d = rdat;
      m_fifo.push_back(f);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      f = exp_q.pop_front();
      chk("wr_en", bus.regfile_write_enable, 1);
      chk("wr_addr", bus.regfile_write_addr, f.a);
      chk("wr_data", bus.regfile_write_data, f.d);
    end else begin
      chk("wr_en_idle", bus.regfile_write_enable, 0);
    end
    chk("rs_busy", bus.rs_busy, m_sb[q]);
    chk("rt_busy", bus.rt_busy, m_sb[q ^ 5'd1]);
    chk("rd_busy", bus.rd_busy, m_sb[q]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r6_at;
    drive_idle();
    bus.rs_query_addr = 5'd8; bus.rt_query_addr = 5'd9; bus.rd_query_addr = 5'd8;
    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wr_en", bus.regfile_write_enable, 0);
    chk("rst_wr_addr", bus.regfile_write_addr, 0);
    chk("rst_wr_data", bus.regfile_write_data, 0);
    chk("rst_stall", bus.pipe_stall, 0);
    chk("rst_issue_ready", bus.ld_issue_ready, 1);
    chk("rst_ret_ready", bus.ld_ret_ready, 1);
    chk("rst_busy", bus.rd_busy, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // pwe pa pd | iv ia | rv ra rd | q || e_en e_a e_d e_busy e_irdy
    vecs.push_back(mk(1'b1,5'd5,32'h1234_5678, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd5, 1'b1,5'd5,32'h1234_5678,1'b0,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd8, 1'b0,5'd0,32'h0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b1,5'd8, 1'b0,5'd0,32'h0, 5'd8, 1'b0,5'd0,32'h0,1'b1,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd8, 1'b0,5'd0,32'h0,1'b1,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b1,5'd8,32'hDEAD_BEEF, 5'd8, 1'b0,5'd0,32'h0,1'b1,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd8, 1'b1,5'd8,32'hDEAD_BEEF,1'b0,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b1,5'd1, 1'b0,5'd0,32'h0, 5'd9, 1'b0,5'd0,32'h0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b1,5'd2, 1'b0,5'd0,32'h0, 5'd1, 1'b0,5'd0,32'h0,1'b1,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b1,5'd3, 1'b0,5'd0,32'h0, 5'd2, 1'b0,5'd0,32'h0,1'b1,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b1,5'd4, 1'b0,5'd0,32'h0, 5'd3, 1'b0,5'd0,32'h0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b1,5'd9, 1'b0,5'd0,32'h0, 5'd9, 1'b0,5'd0,32'h0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b1,5'd1,32'h1111_0001, 5'd1, 1'b0,5'd0,32'h0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd1, 1'b1,5'd1,32'h1111_0001,1'b0,1'b1));
    vecs.push_back(mk(1'b1,5'd10,32'hA, 1'b0,5'd0, 1'b1,5'd3,32'h3333_0003, 5'd3, 1'b1,5'd10,32'hA,1'b1,1'b1));
    vecs.push_back(mk(1'b1,5'd11,32'hB, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd3, 1'b1,5'd11,32'hB,1'b1,1'b1));
    vecs.push_back(mk(1'b1,5'd12,32'hC, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd3, 1'b1,5'd12,32'hC,1'b1,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd3, 1'b1,5'd3,32'h3333_0003,1'b0,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b1,5'd2,32'h2222_0002, 5'd2, 1'b0,5'd0,32'h0,1'b1,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b1,5'd4,32'h4444_0004, 5'd2, 1'b1,5'd2,32'h2222_0002,1'b0,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd4, 1'b1,5'd4,32'h4444_0004,1'b0,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b1,5'd0, 1'b0,5'd0,32'h0, 5'd0, 1'b0,5'd0,32'h0,1'b0,1'b1));
    vecs.push_back(mk(1'b1,5'd0,32'hFFFF_FFFF, 1'b0,5'd0, 1'b1,5'd0,32'h0BAD, 5'd0, 1'b0,5'd0,32'h0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd0, 1'b0,5'd0,32'h0,1'b0,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b1,5'd20, 1'b0,5'd0,32'h0, 5'd20, 1'b0,5'd0,32'h0,1'b1,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b1,5'd21, 1'b0,5'd0,32'h0, 5'd21, 1'b0,5'd0,32'h0,1'b1,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b1,5'd22, 1'b0,5'd0,32'h0, 5'd22, 1'b0,5'd0,32'h0,1'b1,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b1,5'd23, 1'b0,5'd0,32'h0, 5'd23, 1'b0,5'd0,32'h0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b1,5'd20,32'h5, 5'd20, 1'b0,5'd0,32'h0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b1,5'd21,32'h6, 5'd20, 1'b1,5'd20,32'h5,1'b0,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b1,5'd22,32'h7, 5'd21, 1'b1,5'd21,32'h6,1'b0,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b1,5'd23,32'h8, 5'd22, 1'b1,5'd22,32'h7,1'b0,1'b1));
    vecs.push_back(mk(1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd23, 1'b1,5'd23,32'h8,1'b0,1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].iv, vecs[i].ia,
           vecs[i].rv, vecs[i].ra, vecs[i].rd, vecs[i].q);
      $display("vec %0d: we=%0b addr=%0d data=0x%08h rd_busy=%0b issue_ready=%0b", i,
               bus.regfile_write_enable, bus.regfile_write_addr, bus.regfile_write_data,
               bus.rd_busy, bus.ld_issue_ready);
      chk("vec_wr_en", bus.regfile_write_enable, vecs[i].e_en);
      if (vecs[i].e_en) begin
        chk("vec_wr_addr", bus.regfile_write_addr, vecs[i].e_a);
        chk("vec_wr_data", bus.regfile_write_data, vecs[i].e_d);
      end
      chk("vec_rd_busy", bus.rd_busy, vecs[i].e_busy);
      chk("vec_rs_busy", bus.rs_busy, vecs[i].e_busy);
      chk("vec_issue_ready", bus.ld_issue_ready, vecs[i].e_irdy);
    end

    // Overlapped issue and return, one write per cycle once the stream is running.
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 5'd0, 32'h0, (i < 5), 5'(16 + i),
           (i >= 1 && i <= 5), 5'(15 + i), 32'hC000_0000 + 32'(i), 5'(16 + i));
      $display("stream %0d: we=%0b addr=%0d data=0x%08h", i,
               bus.regfile_write_enable, bus.regfile_write_addr, bus.regfile_write_data);
    end

    // r6 sits in the FIFO behind continuous pipeline writes.
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd0, 32'h0, 5'd6);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd6, 32'h6666_0006, 5'd6);
    r6_at = -1;
    for (int k = 0; k <= 12; k++) begin
      step((k < 12) && !(GUARD && (m_starve == 7)), 5'(24 + (k % 4)), 32'hB000_0000 + 32'(k),
           1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd6);
      $display("starve %0d: we=%0b addr=%0d stall=%0b", k,
               bus.regfile_write_enable, bus.regfile_write_addr, bus.pipe_stall);
      if (bus.regfile_write_enable && bus.regfile_write_addr == 5'd6 && r6_at < 0) r6_at = k;
    end
    chk("r6_write_cycle", r6_at, GUARD ? 7 : 12);

    // Reset in the middle of outstanding loads.
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd7);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 1'b0, 5'd0, 32'h0, 5'd7);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h7777_0007, 5'd7);
    drive_idle();
    rst = 1'b0;
    #2;
    $display("mid reset: we=%0b busy7=%0b issue_ready=%0b", bus.regfile_write_enable,
             bus.rd_busy, bus.ld_issue_ready);
    chk("mid_rst_wr_en", bus.regfile_write_enable, 0);
    chk("mid_rst_wr_addr", bus.regfile_write_addr, 0);
    chk("mid_rst_wr_data", bus.regfile_write_data, 0);
    chk("mid_rst_busy", bus.rd_busy, 0);
    chk("mid_rst_issue_ready", bus.ld_issue_ready, 1);
    chk("mid_rst_ret_ready", bus.ld_ret_ready, 1);
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 5'd13, 32'h1313_1313, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd13);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd7);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd7);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end of the GPR file. Merges two producers of register results onto the single regfile write port: the in-order pipeline writeback and out-of-order load returns from the AXI data path. Keeps a scoreboard of registers with loads in flight, so the hazard logic can stall dependent instructions. Sits between MEM/WB and the `regfile` write port (`regfile_write_enable/addr/data`).

## Interface
- `DEPTH`, 4: load-return FIFO entries and maximum outstanding loads; power of 2, ≥2.

- `clk` input 1: core clock.
- `rst` input 1: asynchronous, active-low reset.
- `pipe_we` input 1: pipeline writeback valid; always accepted.
- `pipe_waddr` input 5: pipeline destination register.
- `pipe_wdata` input 32: pipeline result.
- `ld_issue_valid` input 1: a load is issued to the bus this cycle.
- `ld_issue_addr` input 5: destination register of the issued load.
- `ld_issue_ready` output 1: may issue another load (outstanding < DEPTH).
- `ld_ret_valid` input 1: load data returning.
- `ld_ret_addr` input 5: destination register of the returning load.
- `ld_ret_data` input 32: load data.
- `ld_ret_ready` output 1: FIFO not full.
- `rs_query_addr`, `rt_query_addr`, `rd_query_addr` input 5 each: hazard-check addresses from ID.
- `rs_busy`, `rt_busy`, `rd_busy` output 1 each: the queried register has a pending load.
- `pipe_stall` output 1: request a one-cycle pipeline hold (see Configuration).
- `regfile_write_enable` output 1, `regfile_write_addr` output 5, `regfile_write_data` output 32: registered write port to the regfile.

## Operation
- Scoreboard: 32 bits, bit 0 hard-wired 0. Outstanding counter: 0..DEPTH.
- Load issue with `ld_issue_valid && ld_issue_ready` and a non-zero address: sets the bit and increments the counter. Issue to r0 is a no-op.
- Load return with `ld_ret_valid && ld_ret_ready`:
  - non-zero address: pushes {addr, data} into the FIFO;
  - r0: accepted and discarded; FIFO and counter untouched.
- Write-port arbiter, each cycle:
  - `pipe_we` high: select the pipeline write;
  - else FIFO not empty: pop the head;
  - else idle.
- The selected write is registered into `regfile_write_*`. Enable is forced to 0 for address 0.
- On a FIFO pop, the register's scoreboard bit clears and the counter decrements, at the same edge the write output is registered.
- Same-cycle set and clear of one bit: set wins. Simultaneous issue and pop: counter unchanged.
- Busy outputs are combinational: `x_busy = scoreboard[x_query_addr]`.
- Pipeline contract: no pipeline write and no load issue to a busy register. The hazard unit stalls on `rd_busy`. The bench asserts this; the RTL does not correct it.
- The counter limit guarantees the FIFO cannot overflow. `ld_ret_ready` is still driven as `!full`.

## Timing
- Reset (`rst` low, asynchronous): scoreboard clear, counter 0, FIFO empty, starvation counter 0.
  - Output values: `regfile_write_enable`=0, `regfile_write_addr`=0, `regfile_write_data`=0, `pipe_stall`=0, `ld_issue_ready`=1, `ld_ret_ready`=1.
  - Reset mid-operation drops all in-flight loads; the bus side is reset together.
- Pipeline write: `pipe_we` in cycle N, output in cycle N+1, regfile commit at end of N+1. Forwarding must cover the extra stage.
- Load return: accepted in cycle N, popped no earlier than cycle N+1, output in cycle N+2.
  - A busy bit clears at the edge where the output asserts.
  - The regfile's write-to-read bypass makes data visible in that same cycle, when busy is already 0.
- FIFO: no bypass of an empty FIFO. Push and pop in the same cycle are allowed. Pointers wrap modulo DEPTH.
- Issue and full-rate returns sustain one write per cycle when `pipe_we` is low.

## Configuration
- `WB_STARVE_GUARD_EN` defined:
  - a 3-bit counter increments each cycle the FIFO is non-empty and `pipe_we` blocks the pop;
  - it clears on any pop;
  - when it reaches 7, `pipe_stall` is asserted combinationally for one cycle, and the pipeline holds with `pipe_we`=0 in that cycle.
- Not defined: `pipe_stall` is tied to 0, with no counter; load returns may starve behind continuous pipeline writes.

## Test plan
- Reset, then `pipe_we`=1, addr=5, data=0x1234_5678 for one cycle → next cycle `regfile_write_enable`=1, addr=5, data=0x1234_5678, then 0.
- Issue a load to r8 → `rd_busy`/`rs_busy` with query 8 is 1 the next cycle. Return 0xDEAD_BEEF two cycles later → write port shows r8 = 0xDEAD_BEEF; busy is 0 in the same cycle.
- Issue DEPTH=4 loads to r1..r4 → `ld_issue_ready`=0. A fifth `ld_issue_valid` is ignored, and a query on r9 stays 0. Return one load → `ld_issue_ready` returns to 1 after its pop.
- Load return for r3 while `pipe_we`=1 for 3 cycles (r10–r12) → pipeline writes appear in order, then r3 in the 4th cycle; the r3 busy bit stays 1 until then.
- Load issue and return on r0, plus a pipeline write to r0 → `regfile_write_enable` never asserts; the counter is unchanged.
- With `WB_STARVE_GUARD_EN`: FIFO holds r6 while `pipe_we`=1 continuously → `pipe_stall` pulses after 7 blocked cycles; r6 is written while `pipe_we`=0. Without the macro, r6 waits until `pipe_we` drops.
